// File: rtl/btn_event_pkg.sv
// Shared event codes and FSM state encoding for the pushbutton event decoder.
// The DC_WAIT state and DCLICK code are only reachable when BTN_EVENT_DCLICK_EN is defined.
package btn_event_pkg;

    localparam int EV_W = 3;

    localparam logic [EV_W-1:0] EV_NONE      = 3'd0;
    localparam logic [EV_W-1:0] EV_PRESS     = 3'd1;
    localparam logic [EV_W-1:0] EV_LONG      = 3'd2;
    localparam logic [EV_W-1:0] EV_REPEAT    = 3'd3;
    localparam logic [EV_W-1:0] EV_REL_SHORT = 3'd4;
    localparam logic [EV_W-1:0] EV_REL_LONG  = 3'd5;
    localparam logic [EV_W-1:0] EV_DCLICK    = 3'd6;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_DC_WAIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_PRESSED = S_PRESSED,
        ST_HELD    = S_HELD,
        ST_DC_WAIT = S_DC_WAIT
    } state_t;

endpackage

// File: rtl/btn_event_slot.sv
// One-deep valid/ready event holding register with sticky drop flag.
// Latency: push appears on valid the cycle after; a push into a full, unaccepted slot is dropped and sets ovf.
module btn_event_slot
    import btn_event_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [EV_W-1:0] push_code,
    input  logic            ready,
    input  logic            ovf_clr,
    output logic            valid,
    output logic [EV_W-1:0] code,
    output logic            ovf
);

    logic accept;
    logic drop;

    assign accept = valid & ready;
    assign drop   = push & valid & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            code  <= EV_NONE;
            ovf   <= 1'b0;
        end else begin
            if (push && (!valid || accept)) begin
                valid <= 1'b1;
                code  <= push_code;
            end else if (accept) begin
                valid <= 1'b0;
            end
            // A drop in the same cycle as a clear must still be reported.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into PRESS/LONG/REPEAT/RELEASE tokens (DCLICK with BTN_EVENT_DCLICK_EN).
// Latency: event visible one cycle after the edge is sampled; full slot drops new events and flags ovf.
module btn_event_decoder
    import btn_event_pkg::*;
#(
    parameter int               CNT_W         = 24,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = 24'd5_000_000,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1_000_000
`ifdef BTN_EVENT_DCLICK_EN
    ,
    parameter logic [CNT_W-1:0] DCLICK_CYCLES = 24'd2_500_000
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pb_state,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_code,
    input  logic            ev_ready,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_TERM = LONG_CYCLES - ONE;
    localparam logic [CNT_W-1:0] REP_TERM  = REPEAT_CYCLES - ONE;
`ifdef BTN_EVENT_DCLICK_EN
    localparam logic [CNT_W-1:0] DC_TERM   = DCLICK_CYCLES - ONE;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pb_q;
    logic             rise;
    logic             fall;
    logic             long_hit;
    logic             rep_hit;
    logic             dc_hit;
    logic             push;
    logic [EV_W-1:0]  push_code;

    assign rise     = pb_state & ~pb_q;
    assign fall     = ~pb_state & pb_q;
    assign long_hit = (cnt == LONG_TERM);
    assign rep_hit  = (cnt == REP_TERM);
`ifdef BTN_EVENT_DCLICK_EN
    assign dc_hit   = (cnt == DC_TERM);
`else
    assign dc_hit   = 1'b0;
`endif

    // Event decode is combinational so the slot captures it on the same edge the FSM moves.
    always_comb begin
        push      = 1'b0;
        push_code = EV_NONE;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    push      = 1'b1;
                    push_code = EV_PRESS;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    push      = 1'b1;
                    push_code = EV_REL_SHORT;
                end else if (long_hit) begin
                    push      = 1'b1;
                    push_code = EV_LONG;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    push      = 1'b1;
                    push_code = EV_REL_LONG;
                end else if (rep_hit) begin
                    push      = 1'b1;
                    push_code = EV_REPEAT;
                end
            end
            ST_DC_WAIT: begin
                if (rise) begin
                    push      = 1'b1;
                    push_code = dc_hit ? EV_PRESS : EV_DCLICK;
                end
            end
            default: begin
                push      = 1'b0;
                push_code = EV_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pb_q  <= 1'b0;
        end else begin
            pb_q <= pb_state;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rise)
                        state <= ST_PRESSED;
                end
                ST_PRESSED: begin
                    if (fall) begin
                        cnt <= '0;
`ifdef BTN_EVENT_DCLICK_EN
                        state <= ST_DC_WAIT;
`else
                        state <= ST_IDLE;
`endif
                    end else if (long_hit) begin
                        cnt   <= '0;
                        state <= ST_HELD;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (rep_hit) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`ifdef BTN_EVENT_DCLICK_EN
                ST_DC_WAIT: begin
                    // Rise on the timeout cycle still re-enters PRESSED, but as a plain PRESS.
                    if (rise) begin
                        cnt   <= '0;
                        state <= ST_PRESSED;
                    end else if (dc_hit) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`endif
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    btn_event_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_code (push_code),
        .ready     (ev_ready),
        .ovf_clr   (ovf_clr),
        .valid     (ev_valid),
        .code      (ev_code),
        .ovf       (ovf)
    );

endmodule
